// File: rtl/iomem_debug_bridge.sv
// Byte-stream command bridge that initiates PicoSoC iomem read/write transactions
// and streams status plus read data back on a byte-stream response channel.
module iomem_debug_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic        busy
);

    localparam int unsigned CNT_W = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_BUS   = 3'd3;
    localparam logic [2:0] S_RESP  = 3'd4;
    localparam logic [2:0] S_RDATA = 3'd5;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_OK    = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h45;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]       state_q, state_n;
    logic             op_write_q, op_write_n;
    logic [1:0]       idx_q, idx_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic             ok_q, ok_n;
    logic [31:0]      rdata_q, rdata_n;

    logic        rx_ready_n, tx_valid_n, iomem_valid_n, busy_n;
    logic [7:0]  tx_data_n;
    logic [3:0]  wstrb_n;
    logic [31:0] addr_n, wdata_n;

    logic rx_hs, tx_hs;

    assign rx_hs = rx_valid && rx_ready;
    assign tx_hs = tx_valid && tx_ready;

    // Next state plus next value of every registered output.
    always_comb begin
        state_n    = state_q;
        op_write_n = op_write_q;
        idx_n      = idx_q;
        cnt_n      = cnt_q;
        ok_n       = ok_q;
        rdata_n    = rdata_q;
        addr_n     = iomem_addr;
        wdata_n    = iomem_wdata;
        tx_data_n  = tx_data;

        case (state_q)
            S_IDLE: begin
                if (rx_hs && (rx_data == CMD_WRITE || rx_data == CMD_READ)) begin
                    op_write_n = (rx_data == CMD_WRITE);
                    idx_n      = 2'd0;
                    state_n    = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_hs) begin
                    addr_n[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_n = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_n = op_write_q ? S_DATA : S_BUS;
                    end
                end
            end
            S_DATA: begin
                if (rx_hs) begin
                    wdata_n[{idx_q, 3'b000} +: 8] = rx_data;
                    idx_n = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_n = S_BUS;
                    end
                end
            end
            S_BUS: begin
                // A ready in the last wait cycle still beats the timeout.
                if (iomem_ready) begin
                    rdata_n = iomem_rdata;
                    ok_n    = 1'b1;
                    state_n = S_RESP;
                end else if (cnt_q == CNT_LAST) begin
                    ok_n    = 1'b0;
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (tx_hs) begin
                    if (ok_q && !op_write_q) begin
                        idx_n   = 2'd0;
                        state_n = S_RDATA;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            S_RDATA: begin
                if (tx_hs) begin
                    idx_n = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (state_q != S_BUS) begin
            cnt_n = '0;
        end

        rx_ready_n    = (state_n == S_IDLE) || (state_n == S_ADDR) || (state_n == S_DATA);
        iomem_valid_n = (state_n == S_BUS);
        wstrb_n       = (state_n == S_BUS && op_write_n) ? 4'hF : 4'h0;
        tx_valid_n    = (state_n == S_RESP) || (state_n == S_RDATA);
        busy_n        = (state_n != S_IDLE);

        // tx_data only changes when a new byte is presented, so it holds under backpressure.
        if (state_n == S_RESP) begin
            tx_data_n = ok_n ? RSP_OK : RSP_ERR;
        end else if (state_n == S_RDATA) begin
            tx_data_n = rdata_n[{idx_n, 3'b000} +: 8];
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            op_write_q  <= 1'b0;
            idx_q       <= 2'd0;
            cnt_q       <= '0;
            ok_q        <= 1'b0;
            rdata_q     <= '0;
            rx_ready    <= 1'b0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            iomem_valid <= 1'b0;
            iomem_wstrb <= '0;
            iomem_addr  <= '0;
            iomem_wdata <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_n;
            op_write_q  <= op_write_n;
            idx_q       <= idx_n;
            cnt_q       <= cnt_n;
            ok_q        <= ok_n;
            rdata_q     <= rdata_n;
            rx_ready    <= rx_ready_n;
            tx_valid    <= tx_valid_n;
            tx_data     <= tx_data_n;
            iomem_valid <= iomem_valid_n;
            iomem_wstrb <= wstrb_n;
            iomem_addr  <= addr_n;
            iomem_wdata <= wdata_n;
            busy        <= busy_n;
        end
    end

endmodule

// File: tb/tb_iomem_debug_bridge.sv
// Directed self-checking bench for iomem_debug_bridge with a short timeout.
module tb_iomem_debug_bridge;

    logic        clk;
    logic        resetn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    iomem_debug_bridge #(.TIMEOUT_CYCLES(8)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // The two byte channels must never be open at the same time.
    always @(negedge clk) begin
        if (resetn) begin
            checks++;
            assert (!(rx_ready && tx_valid)) else begin
                failures++;
                $error("FAIL rx_tx_exclusive observed=1 expected=0");
            end
        end
    end

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"},    32'(rx_ready),    32'd0);
        check({tag, "_tx_valid"},    32'(tx_valid),    32'd0);
        check({tag, "_tx_data"},     32'(tx_data),     32'd0);
        check({tag, "_iomem_valid"}, 32'(iomem_valid), 32'd0);
        check({tag, "_wstrb"},       32'(iomem_wstrb), 32'd0);
        check({tag, "_addr"},        iomem_addr,       32'd0);
        check({tag, "_wdata"},       iomem_wdata,      32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the byte transferred.
    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        rx_data  = b;
        rx_valid = 1'b1;
        for (int i = 0; i < 20 && !done; i++) begin
            if (rx_ready) done = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check("rx_accept", 32'(done), 32'd1);
    endtask

    task automatic send_cmd(input bit wr, input logic [31:0] a, input logic [31:0] d);
        send_byte(wr ? 8'h57 : 8'h52);
        for (int i = 0; i < 4; i++) send_byte(a[8*i +: 8]);
        if (wr) for (int i = 0; i < 4; i++) send_byte(d[8*i +: 8]);
    endtask

    task automatic bus_chk(input logic [31:0] ea, input logic [31:0] ewd, input logic [3:0] ews);
        check("bus_valid", 32'(iomem_valid), 32'd1);
        check("bus_addr",  iomem_addr,       ea);
        check("bus_wstrb", 32'(iomem_wstrb), 32'(ews));
        if (ews != 4'h0) check("bus_wdata", iomem_wdata, ewd);
    endtask

    // Entered in the first iomem_valid cycle; ready is given dly cycles later.
    task automatic do_bus(input int dly, input logic [31:0] rd, input logic [31:0] ea,
                          input logic [31:0] ewd, input logic [3:0] ews);
        for (int i = 0; i < dly; i++) begin
            bus_chk(ea, ewd, ews);
            @(negedge clk);
        end
        bus_chk(ea, ewd, ews);
        iomem_ready = 1'b1;
        iomem_rdata = rd;
        @(negedge clk);
        iomem_ready = 1'b0;
        iomem_rdata = 32'hFFFF_FFFF;
        check("valid_drop",   32'(iomem_valid), 32'd0);
        check("tx_valid_rise", 32'(tx_valid),   32'd1);
    endtask

    // Collects n response bytes (byte 0 in exp[7:0]); toggle stalls every other cycle.
    task automatic recv(input int n, input bit toggle, input logic [39:0] exp, output int cycles);
        int got = 0;
        cycles = 0;
        while (got < n && cycles < 100) begin
            tx_ready = toggle ? (cycles % 2 == 1) : 1'b1;
            if (tx_valid && tx_ready) begin
                check("rx_byte", 32'(tx_data), 32'(exp[8*got +: 8]));
                got++;
            end else if (tx_valid) begin
                check("hold_byte", 32'(tx_data), 32'(exp[8*got +: 8]));
            end
            @(negedge clk);
            cycles++;
        end
        tx_ready = 1'b1;
        check("recv_count", 32'(got), 32'(n));
    endtask

    initial begin
        int cyc;
        int vcnt;
        rx_valid    = 1'b0;
        rx_data     = 8'h00;
        tx_ready    = 1'b1;
        iomem_ready = 1'b0;
        iomem_rdata = 32'hFFFF_FFFF;
        resetn      = 1'b0;

        repeat (3) @(negedge clk);
        check_reset("reset");
        resetn = 1'b1;
        @(negedge clk);
        check("rx_ready_rise", 32'(rx_ready), 32'd1);

        // Stray ready while idle must be ignored.
        iomem_ready = 1'b1;
        @(negedge clk);
        iomem_ready = 1'b0;
        @(negedge clk);
        check("stray_tx_valid", 32'(tx_valid), 32'd0);
        check("stray_busy",     32'(busy),     32'd0);

        // Write.
        send_cmd(1'b1, 32'h0300_0000, 32'hDEAD_BEEF);
        check("wr_latency", 32'(iomem_valid), 32'd1);
        do_bus(1, 32'h0, 32'h0300_0000, 32'hDEAD_BEEF, 4'hF);
        recv(1, 1'b0, 40'h4B, cyc);
        check("wr_idle_busy",  32'(busy),     32'd0);
        check("wr_idle_ready", 32'(rx_ready), 32'd1);

        // Read with full-rate response.
        send_cmd(1'b0, 32'h0300_0000, 32'h0);
        check("rd_latency", 32'(iomem_valid), 32'd1);
        do_bus(1, 32'h1234_5678, 32'h0300_0000, 32'h0, 4'h0);
        recv(5, 1'b0, 40'h12_34_56_78_4B, cyc);
        check("rd_throughput", 32'(cyc), 32'd5);
        check("rd_idle", 32'(tx_valid), 32'd0);

        // Timeout: valid for exactly 8 cycles, then 'E' only.
        send_cmd(1'b0, 32'h0400_0010, 32'h0);
        vcnt = 0;
        while (iomem_valid && vcnt < 50) begin
            vcnt++;
            @(negedge clk);
        end
        check("to_valid_cycles", 32'(vcnt), 32'd8);
        check("to_tx_valid", 32'(tx_valid), 32'd1);
        recv(1, 1'b0, 40'h45, cyc);
        check("to_no_data", 32'(tx_valid), 32'd0);
        check("to_idle",    32'(busy),     32'd0);

        // Garbage bytes are dropped, then a read under tx backpressure.
        send_byte(8'h00);
        check("garb0_tx", 32'(tx_valid), 32'd0);
        check("garb0_busy", 32'(busy), 32'd0);
        send_byte(8'hFF);
        check("garb1_tx", 32'(tx_valid), 32'd0);
        check("garb1_busy", 32'(busy), 32'd0);
        send_cmd(1'b0, 32'h0300_0004, 32'h0);
        do_bus(0, 32'hCAFE_F00D, 32'h0300_0004, 32'h0, 4'h0);
        recv(5, 1'b1, 40'hCA_FE_F0_0D_4B, cyc);
        check("bp_cycles", 32'(cyc), 32'd10);

        // Ready in the final timeout cycle wins.
        send_cmd(1'b0, 32'h0400_0000, 32'h0);
        do_bus(7, 32'h0BAD_C0DE, 32'h0400_0000, 32'h0, 4'h0);
        recv(5, 1'b0, 40'h0B_AD_C0_DE_4B, cyc);

        // Reset in the middle of a command.
        send_byte(8'h52);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        resetn = 1'b0;
        @(negedge clk);
        check_reset("midrst");
        resetn = 1'b1;
        @(negedge clk);
        check("midrst_rx_ready", 32'(rx_ready), 32'd1);
        send_cmd(1'b1, 32'h0400_0000, 32'h0102_0304);
        check("post_rst_latency", 32'(iomem_valid), 32'd1);
        do_bus(2, 32'h0, 32'h0400_0000, 32'h0102_0304, 4'hF);
        recv(1, 1'b0, 40'h4B, cyc);
        check("post_rst_idle", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
